zc_period_meter: RTL and testbench
==================================

ZC_PERIOD_METER -- requirements
Module: zc_period_meter

Interface
REQ-001 Parameter HYST, default 32'sd100, hysteresis threshold in input LSB (signed, SHALL be >= 0).
REQ-002 Parameter CNT_W, default 16, width of the period counter and period output.
REQ-003 Parameter MIN_PERIOD, default 8, blanking interval in clock cycles after any accepted transition (>= 1).
REQ-004 i_clock  input  1  single clock; all state changes on rising edge.
REQ-005 i_RESET  input  1  asynchronous, active-high reset.
REQ-006 i_data  input  32  signed filtered sample (output of the moving-average stage), one new sample per clock.
REQ-007 o_sign  output  1  hysteresis-qualified sign of i_data (1 = positive half-wave).
REQ-008 o_period  output  CNT_W  last measured period in clock cycles, rising transition to rising transition.
REQ-009 o_valid  output  1  one-cycle pulse, high on the cycle o_period is updated.
REQ-010 o_timeout  output  1  sticky flag: no rising transition within 2^CNT_W-1 cycles.

Function
REQ-011 The block SHALL implement a three-state FSM: INIT, POS, NEG; all comparisons SHALL be signed 32-bit and strict.
REQ-012 INIT -> POS when i_data > HYST; INIT -> NEG when i_data < -HYST; otherwise remain in INIT; neither exit counts as a rising transition.
REQ-013 POS -> NEG (falling transition) when i_data < -HYST and blank counter == 0.
REQ-014 NEG -> POS (rising transition) when i_data > HYST and blank counter == 0.
REQ-015 Samples inside [-HYST, +HYST] SHALL never change state.
REQ-016 o_sign SHALL be registered: 1 in POS, 0 in NEG and INIT, updated on the same edge that samples the qualifying i_data (1-cycle latency).
REQ-017 On every accepted transition (including INIT exits), the blank counter SHALL load MIN_PERIOD-1 and decrement by 1 per cycle to 0; transitions are accepted only when it is 0.
REQ-018 The period counter SHALL clear to 0 on each rising transition edge and increment by 1 on every other edge, saturating at 2^CNT_W-1.
REQ-019 An armed flag SHALL be set by the first rising transition; on each subsequent rising transition with armed = 1, o_period <= counter + 1 and o_valid = 1 for exactly that cycle.
REQ-020 The first rising transition after reset or after a timeout SHALL NOT assert o_valid and SHALL NOT change o_period.
REQ-021 When the period counter reaches saturation, o_timeout SHALL set to 1 and armed SHALL clear; FSM state and o_sign are unaffected.
REQ-022 o_timeout SHALL clear on the next o_valid pulse; o_period SHALL hold its last value while o_timeout = 1.
REQ-023 Falling transitions SHALL affect only FSM state, o_sign and blank counter; they never affect o_period or o_valid.
REQ-024 o_valid SHALL be 0 in every cycle not described in REQ-019.

Reset
REQ-025 While i_RESET = 1, asynchronously: state = INIT, o_sign = 0, o_period = 0, o_valid = 0, o_timeout = 0, period counter = 0, blank counter = 0, armed = 0.
REQ-026 Reset asserted mid-period SHALL discard the partial measurement; after release the first rising transition is again unarmed (REQ-020).
REQ-027 Deassertion SHALL take effect on the first rising edge of i_clock after i_RESET falls; no output changes before it.

Verification
REQ-028 Square wave +/-1000, period 20 cycles (10 high/10 low), defaults -> first rising edge no o_valid; from second onward o_valid every 20 cycles, o_period = 20, o_sign toggles 1 cycle after each input step.
REQ-029 Input oscillating +/-50 (inside HYST=100) after reaching POS -> o_sign stays 1, no o_valid, counter runs.
REQ-030 Glitch: in POS, i_data = -1000 for 1 cycle, 3 cycles after a rising transition, MIN_PERIOD=8 -> ignored, o_sign stays 1; same glitch 9 cycles after -> accepted, o_sign = 0.
REQ-031 CNT_W=8, input held at +1000 after one rising transition -> o_timeout = 1 at counter 255; next two rising transitions 30 cycles apart -> first gives no o_valid, second gives o_valid, o_period = 30, o_timeout = 0.
REQ-032 Assert i_RESET mid-period with o_period = 20 -> all outputs 0 immediately; after release, square wave period 40 -> first valid o_period = 40 on second rising transition.
REQ-033 Input exactly +100 / -100 (= +/-HYST) -> no transitions from INIT, o_sign = 0.

Source files
------------

// File: rtl/zc_period_meter.sv
// Zero-crossing period meter: hysteresis sign detector with blanking,
// rising-to-rising period measurement, valid pulse and sticky timeout.
module zc_period_meter #(
    parameter logic signed [31:0] HYST       = 32'sd100,
    parameter int                 CNT_W      = 16,
    parameter int                 MIN_PERIOD = 8
) (
    input  logic                i_clock,
    input  logic                i_RESET,
    input  logic signed [31:0]  i_data,
    output logic                o_sign,
    output logic [CNT_W-1:0]    o_period,
    output logic                o_valid,
    output logic                o_timeout
);

    localparam logic signed [31:0] NEG_HYST = -HYST;
    localparam int                 BLK_W    = (MIN_PERIOD > 2) ? $clog2(MIN_PERIOD) : 1;
    localparam logic [BLK_W-1:0]   BLK_LOAD = BLK_W'(MIN_PERIOD - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_POS  = 2'd1,
        ST_NEG  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_above;
    logic               w_below;
    logic               w_blank_zero;
    logic               w_accept;
    logic               w_rise;
    logic [BLK_W-1:0]   r_blank;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_sat_nxt;
    logic               r_armed;
    logic               r_sign;
    logic [CNT_W-1:0]   r_period;
    logic               r_valid;
    logic               r_timeout;

    assign w_above      = (i_data > HYST);
    assign w_below      = (i_data < NEG_HYST);
    assign w_blank_zero = (r_blank == '0);

    // State register
    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) r_state <= ST_INIT;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; INIT exits are accepted transitions but not rising ones
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rise      = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (w_above) begin
                    w_state_nxt = ST_POS;
                    w_accept    = 1'b1;
                end else if (w_below) begin
                    w_state_nxt = ST_NEG;
                    w_accept    = 1'b1;
                end
            end
            ST_POS: begin
                if (w_below && w_blank_zero) begin
                    w_state_nxt = ST_NEG;
                    w_accept    = 1'b1;
                end
            end
            ST_NEG: begin
                if (w_above && w_blank_zero) begin
                    w_state_nxt = ST_POS;
                    w_accept    = 1'b1;
                    w_rise      = 1'b1;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Period counter next value: clear on rising transition, else saturating increment
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_rise)                w_cnt_nxt = '0;
        else if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
        w_sat_nxt = (w_cnt_nxt == CNT_MAX);
    end

    // Registered sign, blank counter and period counter
    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            r_sign  <= 1'b0;
            r_blank <= '0;
            r_cnt   <= '0;
        end else begin
            r_sign <= (w_state_nxt == ST_POS);
            if (w_accept)          r_blank <= BLK_LOAD;
            else if (!w_blank_zero) r_blank <= r_blank - 1'b1;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Measurement: timeout is raised on the edge the counter becomes saturated,
    // which also disarms so the next rising transition only re-arms
    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            r_armed   <= 1'b0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_rise) begin
                r_armed <= 1'b1;
                if (r_armed) begin
                    r_period  <= r_cnt + 1'b1;
                    r_valid   <= 1'b1;
                    r_timeout <= 1'b0;
                end
            end else if (w_sat_nxt) begin
                r_armed   <= 1'b0;
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_sign    = r_sign;
    assign o_period  = r_period;
    assign o_valid   = r_valid;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_zc_period_meter.sv
// Directed bench for zc_period_meter: default instance plus a CNT_W=8 instance
// for the timeout scenario.
module tb_zc_period_meter;

    logic               clk;
    logic               rst;
    logic signed [31:0] d0;
    logic signed [31:0] d1;
    logic               s0, v0, t0;
    logic [15:0]        p0;
    logic               s1, v1, t1;
    logic [7:0]         p1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    zc_period_meter u0 (
        .i_clock(clk), .i_RESET(rst), .i_data(d0),
        .o_sign(s0), .o_period(p0), .o_valid(v0), .o_timeout(t0)
    );

    zc_period_meter #(.CNT_W(8)) u1 (
        .i_clock(clk), .i_RESET(rst), .i_data(d1),
        .o_sign(s1), .o_period(p1), .o_valid(v1), .o_timeout(t1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one sample on each instance, then sample outputs 1 time unit after the edge
    task automatic tick(input logic signed [31:0] a, input logic signed [31:0] b);
        d0 = a;
        d1 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        d0  = '0;
        d1  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sign", 32'(s0), 32'd0);
        chk("rst_period", 32'(p0), 32'd0);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_timeout", 32'(t0), 32'd0);
        rst = 1'b0;

        // Exactly +/-HYST never leaves INIT
        for (int i = 0; i < 3; i++) begin
            tick(32'sd100, 32'sd0);
            chk("hyst_eq_pos_sign", 32'(s0), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(-32'sd100, 32'sd0);
            chk("hyst_eq_neg_sign", 32'(s0), 32'd0);
        end

        // INIT -> POS, then +/-50 inside the band keeps POS
        tick(32'sd1000, 32'sd0);
        chk("init_exit_sign", 32'(s0), 32'd1);
        chk("init_exit_valid", 32'(v0), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick((i % 2 == 0) ? 32'sd50 : -32'sd50, 32'sd0);
            chk("band_sign", 32'(s0), 32'd1);
            chk("band_valid", 32'(v0), 32'd0);
        end

        // Into NEG, then square wave +/-1000, 20-cycle period
        tick(-32'sd1000, 32'sd0);
        chk("fall_sign", 32'(s0), 32'd0);
        repeat (9) tick(-32'sd1000, 32'sd0);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 20; i++) begin
                tick((i < 10) ? 32'sd1000 : -32'sd1000, 32'sd0);
                chk("sq20_sign", 32'(s0), (i < 10) ? 32'd1 : 32'd0);
                chk("sq20_valid", 32'(v0), (i == 0 && p > 0) ? 32'd1 : 32'd0);
                if (i == 0) chk("sq20_period", 32'(p0), (p == 0) ? 32'd0 : 32'd20);
                chk("sq20_timeout", 32'(t0), 32'd0);
            end
        end

        // Glitch rejection within blanking, acceptance after it
        tick(32'sd1000, 32'sd0);
        chk("glitch_rise_valid", 32'(v0), 32'd1);
        chk("glitch_rise_period", 32'(p0), 32'd20);
        repeat (2) tick(32'sd1000, 32'sd0);
        tick(-32'sd1000, 32'sd0);
        chk("glitch3_sign", 32'(s0), 32'd1);
        repeat (5) tick(32'sd1000, 32'sd0);
        tick(-32'sd1000, 32'sd0);
        chk("glitch9_sign", 32'(s0), 32'd0);
        chk("glitch9_valid", 32'(v0), 32'd0);
        repeat (10) tick(-32'sd1000, 32'sd0);
        tick(32'sd1000, 32'sd0);
        chk("pre_rst_valid", 32'(v0), 32'd1);
        chk("pre_rst_period", 32'(p0), 32'd20);
        repeat (3) tick(32'sd1000, 32'sd0);
        chk("pre_rst_sign", 32'(s0), 32'd1);

        // Asynchronous reset mid-period
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sign", 32'(s0), 32'd0);
        chk("async_rst_period", 32'(p0), 32'd0);
        chk("async_rst_valid", 32'(v0), 32'd0);
        chk("async_rst_timeout", 32'(t0), 32'd0);
        tick(32'sd1000, 32'sd0);
        rst = 1'b0;
        #3;
        chk("rst_release_sign", 32'(s0), 32'd0);

        // Square wave with 40-cycle period after reset
        tick(-32'sd1000, 32'sd0);
        chk("sq40_init_sign", 32'(s0), 32'd0);
        repeat (19) tick(-32'sd1000, 32'sd0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 40; i++) begin
                tick((i < 20) ? 32'sd1000 : -32'sd1000, 32'sd0);
                chk("sq40_valid", 32'(v0), (i == 0 && p > 0) ? 32'd1 : 32'd0);
                if (i == 0) chk("sq40_period", 32'(p0), (p == 0) ? 32'd0 : 32'd40);
            end
        end

        // Timeout on the CNT_W=8 instance
        rst = 1'b1;
        tick(32'sd0, 32'sd0);
        tick(32'sd0, 32'sd0);
        rst = 1'b0;
        repeat (9) tick(32'sd0, -32'sd1000);
        tick(32'sd0, 32'sd1000);
        chk("to_first_rise_valid", 32'(v1), 32'd0);
        chk("to_first_rise_sign", 32'(s1), 32'd1);
        repeat (254) tick(32'sd0, 32'sd1000);
        chk("to_before_sat", 32'(t1), 32'd0);
        tick(32'sd0, 32'sd1000);
        chk("to_at_sat", 32'(t1), 32'd1);
        chk("to_sign_kept", 32'(s1), 32'd1);
        repeat (5) tick(32'sd0, 32'sd1000);
        repeat (10) tick(32'sd0, -32'sd1000);
        tick(32'sd0, 32'sd1000);
        chk("to_rearm_valid", 32'(v1), 32'd0);
        chk("to_rearm_timeout", 32'(t1), 32'd1);
        chk("to_rearm_period", 32'(p1), 32'd0);
        repeat (14) tick(32'sd0, 32'sd1000);
        repeat (15) tick(32'sd0, -32'sd1000);
        tick(32'sd0, 32'sd1000);
        chk("to_meas_valid", 32'(v1), 32'd1);
        chk("to_meas_period", 32'(p1), 32'd30);
        chk("to_meas_timeout", 32'(t1), 32'd0);
        tick(32'sd0, 32'sd1000);
        chk("to_valid_pulse_end", 32'(v1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
